// File: rtl/quadrature_clock_ctrl.sv
// Quadrature clock sequencer: divides clk by a runtime ratio and steps a 2-bit phase
// to produce I/Q square waves, with period-aligned stop and deferred reconfiguration.
module quadrature_clock_ctrl #(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_dir,
  input  logic             cfg_load,
  output logic             cfg_ack,
  output logic             out_i,
  output logic             out_q,
  output logic [1:0]       phase,
  output logic             running,
  output logic             cycle_done
);

  localparam logic [1:0]       IDLE      = 2'd0;
  localparam logic [1:0]       RUN       = 2'd1;
  localparam logic [1:0]       STOPPING  = 2'd2;
  localparam logic [DIV_W-1:0] PRESC_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_INIT  = DIV_W'(DIV_RESET);

  logic [1:0]       state, state_n;
  logic [DIV_W-1:0] presc, presc_n;
  logic [DIV_W-1:0] div_act, div_n;
  logic             dir_act, dir_n;
  logic [DIV_W-1:0] pend_div, pend_div_n;
  logic             pend_dir, pend_dir_n;
  logic             pending, pending_n;
  logic [1:0]       phase_n, phase_step;
  logic             tick, wrap;
  logic             ack_n, done_n, run_n, i_n, q_n;

  // Next-state, prescaler, phase and configuration handshake
  always_comb begin
    tick       = (state != IDLE) && (presc == div_act);
    phase_step = dir_act ? (phase - 2'd1) : (phase + 2'd1);
    wrap       = tick && (phase_step == 2'd0);
    state_n    = state;
    presc_n    = presc;
    phase_n    = phase;
    div_n      = div_act;
    dir_n      = dir_act;
    pend_div_n = pend_div;
    pend_dir_n = pend_dir;
    pending_n  = pending;
    ack_n      = 1'b0;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        presc_n = '0;
        phase_n = 2'd0;
        if (cfg_load) begin
          div_n     = cfg_div;
          dir_n     = cfg_dir;
          pending_n = 1'b0;
          ack_n     = 1'b1;
        end else if (pending) begin
          // A load that landed on the stopping wrap is still owed its activation
          div_n     = pend_div;
          dir_n     = pend_dir;
          pending_n = 1'b0;
          ack_n     = 1'b1;
        end else begin
          pending_n = 1'b0;
        end
        state_n = en ? RUN : IDLE;
      end
      RUN, STOPPING: begin
        if (tick) begin
          presc_n = '0;
          phase_n = phase_step;
        end else begin
          presc_n = presc + PRESC_ONE;
          phase_n = phase;
        end
        if (wrap) begin
          done_n = 1'b1;
          if (pending) begin
            div_n     = pend_div;
            dir_n     = pend_dir;
            pending_n = 1'b0;
            ack_n     = 1'b1;
          end else begin
            pending_n = 1'b0;
          end
        end else begin
          pending_n = pending;
        end
        // A load on the wrap edge queues behind the value being applied there
        if (cfg_load) begin
          pend_div_n = cfg_div;
          pend_dir_n = cfg_dir;
          pending_n  = 1'b1;
        end else begin
          pend_div_n = pend_div;
        end
        if (en) begin
          state_n = RUN;
        end else if ((state == STOPPING) && wrap) begin
          state_n = IDLE;
        end else begin
          state_n = STOPPING;
        end
      end
      default: begin
        state_n = IDLE;
        presc_n = '0;
        phase_n = 2'd0;
      end
    endcase
    run_n = (state_n != IDLE);
    i_n   = run_n && ((phase_n == 2'd0) || (phase_n == 2'd1));
    q_n   = run_n && ((phase_n == 2'd1) || (phase_n == 2'd2));
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      presc      <= '0;
      phase      <= 2'd0;
      div_act    <= DIV_INIT;
      dir_act    <= 1'b0;
      pend_div   <= '0;
      pend_dir   <= 1'b0;
      pending    <= 1'b0;
      cfg_ack    <= 1'b0;
      cycle_done <= 1'b0;
      running    <= 1'b0;
      out_i      <= 1'b0;
      out_q      <= 1'b0;
    end else begin
      state      <= state_n;
      presc      <= presc_n;
      phase      <= phase_n;
      div_act    <= div_n;
      dir_act    <= dir_n;
      pend_div   <= pend_div_n;
      pend_dir   <= pend_dir_n;
      pending    <= pending_n;
      cfg_ack    <= ack_n;
      cycle_done <= done_n;
      running    <= run_n;
      out_i      <= i_n;
      out_q      <= q_n;
    end
  end

endmodule
